// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared encodings for the fetch sequencer.
//   BR_*        branch condition codes presented by the EX stage
//   FETCH_*     3-bit fetch FSM state encodings
//   RESET_PC_DEFAULT  default reset program counter
//   addr_aligned()    word-alignment test for branch targets
package fetch_seq_pkg;

  localparam logic [2:0] BR_NO = 3'd0;
  localparam logic [2:0] BR_GO = 3'd1;
  localparam logic [2:0] BR_EQ = 3'd2;
  localparam logic [2:0] BR_NE = 3'd3;
  localparam logic [2:0] BR_GE = 3'd4;
  localparam logic [2:0] BR_LT = 3'd5;

  localparam logic [2:0] FETCH_BOOT  = 3'd0;
  localparam logic [2:0] FETCH_REQ   = 3'd1;
  localparam logic [2:0] FETCH_VALID = 3'd2;
  localparam logic [2:0] FETCH_DRAIN = 3'd3;
  localparam logic [2:0] FETCH_FLUSH = 3'd4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic addr_aligned(input logic [31:0] a);
    return (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_seq_br_eval.sv
// br_eval: combinational branch condition evaluator.
//   i_op    BR_* condition code
//   i_cmp   ALU compare result C
//   o_taken 1 when the condition holds (GE/LT use the sign of C)
module br_eval
  import fetch_seq_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_cmp,
  output logic        o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_op)
      BR_NO:   o_taken = 1'b0;
      BR_GO:   o_taken = 1'b1;
      BR_EQ:   o_taken = (i_cmp == '0);
      BR_NE:   o_taken = (i_cmp != '0);
      BR_GE:   o_taken = !i_cmp[31];
      BR_LT:   o_taken = i_cmp[31];
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: PC sequencer and single-outstanding fetch controller.
//   clk, rst_n                  clock, synchronous active-low reset
//   stall_i                     decode cannot accept inst_o
//   br_valid_i/op/cmp/target    branch resolution from EX
//   imem_req_o/addr_o           instruction memory request (held until ack)
//   imem_ack_i/rdata_i          memory response
//   inst_valid_o/inst_o/inst_pc_o  instruction to decode
//   flush_o                     kill younger stages (DRAIN and FLUSH)
//   misalign_o                  pulse on taken branch to unaligned target
//   taken_cnt_o                 saturating count of accepted redirects
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [2:0]  br_op_i,
  input  logic [31:0] br_cmp_i,
  input  logic [31:0] br_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        flush_o,
  output logic        misalign_o,
  output logic [15:0] taken_cnt_o
);

  // Counter counts down to 0 inclusive, so load one less than the window.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [3:0]  r_flush_cnt;
  logic [15:0] r_taken_cnt;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic        r_misalign;

  logic w_taken;
  logic w_aligned;
  logic w_redirect;
  logic w_req;

  br_eval u_br_eval (
    .i_op    (br_op_i),
    .i_cmp   (br_cmp_i),
    .o_taken (w_taken)
  );

  assign w_aligned  = addr_aligned(br_target_i);
  assign w_redirect = br_valid_i && w_taken && w_aligned && (r_state != FETCH_BOOT);
  assign w_req      = (r_state == FETCH_REQ) || (r_state == FETCH_DRAIN);

  assign imem_req_o   = w_req;
  // r_req_addr is captured on entry to REQ, so DRAIN keeps presenting the
  // abandoned address even though r_pc already holds the branch target.
  assign imem_addr_o  = w_req ? r_req_addr : '0;
  assign inst_valid_o = r_inst_valid;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
  assign flush_o      = (r_state == FETCH_DRAIN) || (r_state == FETCH_FLUSH);
  assign misalign_o   = r_misalign;
  assign taken_cnt_o  = r_taken_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FETCH_BOOT;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_flush_cnt  <= '0;
      r_taken_cnt  <= '0;
      r_inst       <= '0;
      r_inst_pc    <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign <= br_valid_i && w_taken && !w_aligned;

      if (w_redirect) begin
        r_pc <= br_target_i;
        if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 16'd1;
      end

      case (r_state)
        FETCH_BOOT: begin
          r_state    <= FETCH_REQ;
          r_req_addr <= r_pc;
        end
        FETCH_REQ: begin
          if (w_redirect) begin
            if (imem_ack_i) begin
              r_state     <= FETCH_FLUSH;
              r_flush_cnt <= FLUSH_LOAD;
            end else begin
              r_state <= FETCH_DRAIN;
            end
          end else if (imem_ack_i) begin
            r_inst       <= imem_rdata_i;
            r_inst_pc    <= r_req_addr;
            r_inst_valid <= 1'b1;
            r_state      <= FETCH_VALID;
          end
        end
        FETCH_VALID: begin
          if (w_redirect) begin
            r_inst_valid <= 1'b0;
            r_state      <= FETCH_FLUSH;
            r_flush_cnt  <= FLUSH_LOAD;
          end else if (!stall_i) begin
            r_pc         <= r_pc + 32'd4;
            r_req_addr   <= r_pc + 32'd4;
            r_inst_valid <= 1'b0;
            r_state      <= FETCH_REQ;
          end
        end
        FETCH_DRAIN: begin
          if (imem_ack_i) begin
            r_state     <= FETCH_FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
          end
        end
        FETCH_FLUSH: begin
          if (w_redirect) begin
            r_flush_cnt <= FLUSH_LOAD;
          end else if (r_flush_cnt == '0) begin
            r_state    <= FETCH_REQ;
            r_req_addr <= r_pc;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        default: r_state <= FETCH_BOOT;
      endcase
    end
  end

endmodule
